// File: rtl/phy_rx_lanes_if.sv
// ---------------------------------------------------------------------------
// phy_rx_lanes_if -- bundle between the serial lanes of the TX PHY and the
// multi-lane receiver.
//
//   data_serial  [LANES]          one serial bit per lane per cycle, MSB first
//   active       [LANES]          per-lane activation flag
//   data_output  [8*WORD_BYTES]   merged word, first received byte in MSB
//   valid_out                     one-cycle strobe qualifying data_output
//   overflow_err [LANES]          sticky per-lane word-dropped flag
//
// Modports: master = side that drives the serial lanes and observes status,
//           slave  = the receiver.
// ---------------------------------------------------------------------------
interface phy_rx_lanes_if #(
    parameter int LANES      = 2,
    parameter int WORD_BYTES = 4
);
    logic [LANES-1:0]        data_serial;
    logic [LANES-1:0]        active;
    logic [8*WORD_BYTES-1:0] data_output;
    logic                    valid_out;
    logic [LANES-1:0]        overflow_err;

    modport master (
        output data_serial,
        input  active, data_output, valid_out, overflow_err
    );

    modport slave (
        input  data_serial,
        output active, data_output, valid_out, overflow_err
    );
endinterface

// File: rtl/phy_rx_lanes.sv
// ---------------------------------------------------------------------------
// phy_rx_lanes -- parametrised multi-lane PHY receiver on the serial bit clock.
//
// Each lane deserialises its bit stream MSB first, aligns to COMMA bytes,
// goes active after ACT_COUNT consecutive aligned commas, strips COMMA/IDLE
// bytes and assembles data bytes into words (first byte in the MSB byte).
// Completed words sit in a one-deep per-lane holding register; a round-robin
// merge drains them in strict lane order onto one word output.
//
// Ports (top):
//   clk_32f  serial bit clock, the only clock
//   reset    asynchronous, active-low
//   bus      phy_rx_lanes_if.slave (data_serial in; active, data_output,
//            valid_out, overflow_err out)
//
// Optional feature (macro RX_IDLE_FLUSH_EN): an IDLE byte arriving while a
// word is partially assembled completes that word with zero low bytes.
// ---------------------------------------------------------------------------

// Per-lane receive path: deserialiser, alignment FSM, word assembler and
// one-deep holding register with overflow detection.
module phy_rx_lane #(
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         ACT_COUNT  = 4
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    consume,     // merge takes the held word this edge
    output logic                    active,
    output logic                    pending,
    output logic [8*WORD_BYTES-1:0] hold,
    output logic                    overflow_err
);
    localparam int DW = 8*WORD_BYTES;
    localparam int CW = $clog2(ACT_COUNT+1);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0] ACT_LAST = CW'(ACT_COUNT-1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BYTES-1);

    typedef enum logic [1:0] {SEARCH, ALIGNED, ACTIVE} lane_state_e;

    lane_state_e   state, state_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] comma_cnt, comma_nxt;
    logic [IW-1:0] byte_idx, idx_nxt;
    logic [DW-1:0] asm_word, asm_nxt;
    logic [DW-1:0] word;
    logic [DW-1:0] hold_nxt;
    logic          word_done;
    logic          boundary;
    logic          pend_after;
    logic          pend_nxt, ovf_nxt;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            shift        <= '0;
            bit_cnt      <= '0;
            comma_cnt    <= '0;
            byte_idx     <= '0;
            asm_word     <= '0;
            hold         <= '0;
            pending      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift        <= shift_nxt;
            bit_cnt      <= bit_cnt_nxt;
            comma_cnt    <= comma_nxt;
            byte_idx     <= idx_nxt;
            asm_word     <= asm_nxt;
            hold         <= hold_nxt;
            pending      <= pend_nxt;
            overflow_err <= ovf_nxt;
        end
    end

    always_comb begin
        shift_nxt   = {shift[6:0], bit_in};
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        comma_nxt   = comma_cnt;
        idx_nxt     = byte_idx;
        asm_nxt     = asm_word;
        word        = asm_word;
        word_done   = 1'b0;
        boundary    = (bit_cnt == 3'd7);

        case (state)
            SEARCH: begin
                // Bitwise hunt; a hit makes the next bit the first of a byte.
                bit_cnt_nxt = 3'd0;
                if (shift_nxt == COMMA) begin
                    comma_nxt = CW'(1);
                    state_nxt = ALIGNED;
                end
            end
            ALIGNED: begin
                if (boundary) begin
                    if (shift_nxt == COMMA) begin
                        comma_nxt = comma_cnt + CW'(1);
                        if (comma_cnt == ACT_LAST) state_nxt = ACTIVE;
                    end else begin
                        comma_nxt = '0;
                        state_nxt = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (shift_nxt == IDLE) begin
`ifdef RX_IDLE_FLUSH_EN
                        // Assembler is cleared after every word, so the
                        // unfilled low bytes are already zero.
                        if (byte_idx != '0) begin
                            word_done = 1'b1;
                            asm_nxt   = '0;
                            idx_nxt   = '0;
                        end
`endif
                    end else if (shift_nxt != COMMA) begin
                        word[8*(WORD_BYTES-1-int'(byte_idx)) +: 8] = shift_nxt;
                        if (byte_idx == IDX_LAST) begin
                            word_done = 1'b1;
                            asm_nxt   = '0;
                            idx_nxt   = '0;
                        end else begin
                            asm_nxt = word;
                            idx_nxt = byte_idx + IW'(1);
                        end
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // A slot freed by the merge on this edge may be refilled on the same edge.
    always_comb begin
        pend_after = pending & ~consume;
        pend_nxt   = pend_after;
        hold_nxt   = hold;
        ovf_nxt    = overflow_err;
        if (word_done) begin
            if (!pend_after) begin
                hold_nxt = word;
                pend_nxt = 1'b1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    assign active = (state == ACTIVE);
endmodule

module phy_rx_lanes #(
    parameter int         LANES      = 2,
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         ACT_COUNT  = 4
) (
    input  logic           clk_32f,
    input  logic           reset,
    phy_rx_lanes_if.slave  bus
);
    localparam int DW    = 8*WORD_BYTES;
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES-1);

    logic [LANES-1:0]          lane_active;
    logic [LANES-1:0]          lane_ovf;
    logic [LANES-1:0]          pending;
    logic [LANES-1:0]          consume;
    logic [LANES-1:0][DW-1:0]  hold;
    logic [PTR_W-1:0]          ptr;
    logic [DW-1:0]             data_q;
    logic                      valid_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        phy_rx_lane #(
            .WORD_BYTES (WORD_BYTES),
            .COMMA      (COMMA),
            .IDLE       (IDLE),
            .ACT_COUNT  (ACT_COUNT)
        ) u_lane (
            .clk_32f      (clk_32f),
            .reset        (reset),
            .bit_in       (bus.data_serial[gi]),
            .consume      (consume[gi]),
            .active       (lane_active[gi]),
            .pending      (pending[gi]),
            .hold         (hold[gi]),
            .overflow_err (lane_ovf[gi])
        );
    end

    // Only the lane under the pointer can be drained; others wait their turn.
    always_comb begin
        consume      = '0;
        consume[ptr] = pending[ptr];
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (pending[ptr]) begin
            data_q  <= hold[ptr];
            valid_q <= 1'b1;
            ptr     <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.active       = lane_active;
    assign bus.overflow_err = lane_ovf;
    assign bus.data_output  = data_q;
    assign bus.valid_out    = valid_q;
endmodule
